// File: rtl/dmem_arb_if.sv
// dmem_arb_if -- bundle of the two requester ports and the dmem-side bus
// of the data-memory arbiter.
// `ADDR_LEN / `DATA_LEN normally come from the core's constants.vh. They
// fall back to 32 here so that this bundle builds stand-alone.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

interface dmem_arb_if;
  // port 0 (LSU)
  logic                 p0_req;
  logic                 p0_we;
  logic [`ADDR_LEN-1:0] p0_addr;
  logic [`DATA_LEN-1:0] p0_wdata;
  logic                 p0_gnt;
  logic                 p0_rvalid;
  logic [`DATA_LEN-1:0] p0_rdata;
  // port 1 (debug/DMA)
  logic                 p1_req;
  logic                 p1_we;
  logic [`ADDR_LEN-1:0] p1_addr;
  logic [`DATA_LEN-1:0] p1_wdata;
  logic                 p1_gnt;
  logic                 p1_rvalid;
  logic [`DATA_LEN-1:0] p1_rdata;
  // dmem side
  logic [`ADDR_LEN-1:0] mem_addr;
  logic [`DATA_LEN-1:0] mem_wdata;
  logic                 mem_we;
  logic [`DATA_LEN-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // requesters + memory side
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb.sv
// dmem_arb -- two-port data-memory arbiter, zero-cycle grant, one access
// per cycle, 1-cycle load return tagged to the requesting port.
// Config macro: DMEM_ARB_RR_EN -- round-robin under contention; without it
// port 0 has fixed priority and no pointer register exists.
module dmem_arb (
  input  logic        clk,
  input  logic        reset_x,
  dmem_arb_if.slave   bus
);

  logic p0_win;   // port 0 wins if both request
  logic gnt0, gnt1;
  logic [1:0] rtag; // registered return tag: [0] port 0, [1] port 1

`ifdef DMEM_ARB_RR_EN
  logic last_p1;  // 1 = port 1 was granted last

  // pointer moves only on an accepted grant; reset means "port 1 last"
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x)  last_p1 <= 1'b1;
    else if (gnt0) last_p1 <= 1'b0;
    else if (gnt1) last_p1 <= 1'b1;
  end

  assign p0_win = last_p1;
`else
  assign p0_win = 1'b1;
`endif

  // grants are held low while reset is asserted so nothing is accepted
  assign gnt0 = reset_x & bus.p0_req & (~bus.p1_req | p0_win);
  assign gnt1 = reset_x & bus.p1_req & (~bus.p0_req | ~p0_win);

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;

  // idle bus follows port 0; only mem_we qualifies the access
  assign bus.mem_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
  assign bus.mem_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
  assign bus.mem_we    = (gnt0 & bus.p0_we) | (gnt1 & bus.p1_we);

  // a granted load sets the tag for the port for exactly the next cycle
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) rtag <= 2'b00;
    else          rtag <= {gnt1 & ~bus.p1_we, gnt0 & ~bus.p0_we};
  end

  assign bus.p0_rvalid = rtag[0];
  assign bus.p1_rvalid = rtag[1];
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb -- directed vector table, reset-in-flight sequence and a
// random-traffic scoreboard run against a 1-cycle synchronous memory model.
// Build with +define+DMEM_ARB_RR_EN to check the round-robin variant.
module tb_dmem_arb;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  dmem_arb_if bus();

  dmem_arb dut (.clk(clk), .reset_x(reset_x), .bus(bus));

  always #5 clk = ~clk;

  // memory model: 256 words, read data registered one cycle after address
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0;
    logic        r1, w1;
    logic [31:0] a1, wd;
    logic        eg0, eg1, ewe, ev0, ev1;
    logic [31:0] erd;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  task automatic drive(input logic r0, w0, input logic [31:0] a0,
                       input logic r1, w1, input logic [31:0] a1, wd);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = wd;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = wd;
  endtask

  // random requester state
  logic g0, g1, pend0, pend1, last1;
  logic [31:0] exp0, exp1;
  int ld0, ld1, rv0, rv1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[4] = 32'hDEAD_BEEF;

    //          r0 w0 a0     r1 w1 a1     wd            eg0 eg1 ewe ev0 ev1 erd
    tv[0]  = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0};
    tv[1]  = '{1, 0, 32'h10, 0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0};
    tv[2]  = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'hDEADBEEF};
    tv[3]  = '{0, 0, 32'h0,  1, 1, 32'h20, 32'h12345678, 0, 1, 1, 0, 0, 32'h0};
    tv[4]  = '{0, 0, 32'h0,  1, 0, 32'h20, 32'h0,        0, 1, 0, 0, 0, 32'h0};
    tv[5]  = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 32'h12345678};
    tv[6]  = '{1, 0, 32'h30, 1, 0, 32'h40, 32'h0,        1, 0, 0, 0, 0, 32'h0};
    tv[7]  = '{1, 0, 32'h30, 1, 0, 32'h40, 32'h0,        !RR, RR, 0, 1, 0, 32'h1000000C};
    tv[8]  = '{1, 0, 32'h30, 1, 0, 32'h40, 32'h0,        1, 0, 0, !RR, RR, RR ? 32'h10000010 : 32'h1000000C};
    tv[9]  = '{1, 0, 32'h30, 1, 0, 32'h40, 32'h0,        !RR, RR, 0, 1, 0, 32'h1000000C};
    tv[10] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, !RR, RR, RR ? 32'h10000010 : 32'h1000000C};
    tv[11] = '{1, 1, 32'h30, 1, 0, 32'h40, 32'hCAFEF00D, 1, 0, 1, 0, 0, 32'h0};
    tv[12] = '{0, 0, 32'h0,  1, 0, 32'h40, 32'h0,        0, 1, 0, 0, 0, 32'h0};
    tv[13] = '{1, 0, 32'h30, 0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 1, 32'h10000010};
    tv[14] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'hCAFEF00D};

    // reset state with both ports requesting stores
    drive(1, 1, 32'h44, 1, 1, 32'h48, 32'h5555AAAA);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt0", bus.p0_gnt, 0);
    chk("rst_gnt1", bus.p1_gnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_rvalid0", bus.p0_rvalid, 0);
    chk("rst_rvalid1", bus.p1_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 reset_x = 1'b1;

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tv[i].r0, tv[i].w0, tv[i].a0, tv[i].r1, tv[i].w1, tv[i].a1, tv[i].wd);
      #1;
      chk($sformatf("v%0d_gnt0", i), bus.p0_gnt, tv[i].eg0);
      chk($sformatf("v%0d_gnt1", i), bus.p1_gnt, tv[i].eg1);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, tv[i].ewe);
      chk($sformatf("v%0d_rvalid0", i), bus.p0_rvalid, tv[i].ev0);
      chk($sformatf("v%0d_rvalid1", i), bus.p1_rvalid, tv[i].ev1);
      if (tv[i].eg0 || tv[i].eg1)
        chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, tv[i].eg1 ? tv[i].a1 : tv[i].a0);
      if (tv[i].ev0) chk($sformatf("v%0d_rdata0", i), bus.p0_rdata, tv[i].erd);
      if (tv[i].ev1) chk($sformatf("v%0d_rdata1", i), bus.p1_rdata, tv[i].erd);
    end

    // reset while a p0 load is in flight; p0 granted last beforehand
    @(posedge clk); #1;
    drive(1, 0, 32'h50, 0, 0, 0, 0);
    @(posedge clk); #1;                 // first load accepted, second presented
    #1;
    chk("rf_gnt0", bus.p0_gnt, 1);
    chk("rf_rv0_before", bus.p0_rvalid, 1);
    reset_x = 1'b0;
    #1;
    chk("rf_rv0_async", bus.p0_rvalid, 0);
    drive(1, 1, 32'h50, 1, 1, 32'h54, 32'h0BAD0BAD);
    #1;
    chk("rf_gnt0_rst", bus.p0_gnt, 0);
    chk("rf_gnt1_rst", bus.p1_gnt, 0);
    chk("rf_mem_we_rst", bus.mem_we, 0);
    @(posedge clk); #1;
    chk("rf_rv0_after_edge", bus.p0_rvalid, 0);
    chk("rf_mem_we_hold", bus.mem_we, 0);
    drive(1, 0, 32'h50, 1, 0, 32'h54, 32'h0);
    reset_x = 1'b1;
    #1;
    chk("rf_first_gnt0", bus.p0_gnt, 1);
    chk("rf_first_gnt1", bus.p1_gnt, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rf_rv0_first", bus.p0_rvalid, 1);
    chk("rf_rdata_first", bus.p0_rdata, 32'h10000014);

    // random traffic with holding requesters and a scoreboard
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    g0 = 0; g1 = 0; pend0 = 0; pend1 = 0; last1 = 0;
    exp0 = 0; exp1 = 0; ld0 = 0; ld1 = 0; rv0 = 0; rv1 = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      chk("rnd_rvalid0", bus.p0_rvalid, pend0);
      chk("rnd_rvalid1", bus.p1_rvalid, pend1);
      if (bus.p0_rvalid) rv0++;
      if (bus.p1_rvalid) rv1++;
      if (pend0) chk("rnd_rdata0", bus.p0_rdata, exp0);
      if (pend1) chk("rnd_rdata1", bus.p1_rdata, exp1);
      if (!bus.p0_req || g0) begin
        bus.p0_req = ($urandom_range(0, 3) != 0);
        bus.p0_we = $urandom_range(0, 1);
        bus.p0_addr = {24'h0, $urandom_range(0, 63) << 2};
        bus.p0_wdata = $urandom;
      end
      if (!bus.p1_req || g1) begin
        bus.p1_req = ($urandom_range(0, 2) != 0);
        bus.p1_we = $urandom_range(0, 1);
        bus.p1_addr = {24'h0, $urandom_range(0, 63) << 2};
        bus.p1_wdata = $urandom;
      end
      #1;
      g0 = bus.p0_gnt;
      g1 = bus.p1_gnt;
      if (g0 && g1) chk("rnd_both_gnt", {g0, g1}, 2'b00);
      if (g0 && !bus.p0_req) chk("rnd_gnt0_noreq", g0, 0);
      if (g1 && !bus.p1_req) chk("rnd_gnt1_noreq", g1, 0);
      if (bus.p0_req || bus.p1_req) begin
`ifdef DMEM_ARB_RR_EN
        if (bus.p0_req && bus.p1_req) chk("rnd_rr_gnt1", g1, !last1);
        else chk("rnd_single_gnt1", g1, bus.p1_req);
`else
        chk("rnd_fixed_gnt1", g1, bus.p1_req && !bus.p0_req);
`endif
        chk("rnd_gnt0", g0, !g1);
        chk("rnd_mem_we", bus.mem_we, g1 ? bus.p1_we : bus.p0_we);
        chk("rnd_mem_addr", bus.mem_addr, g1 ? bus.p1_addr : bus.p0_addr);
      end else begin
        chk("rnd_idle_we", bus.mem_we, 0);
      end
      pend0 = g0 && !bus.p0_we;
      pend1 = g1 && !bus.p1_we;
      if (pend0) begin exp0 = shadow[bus.p0_addr[9:2]]; ld0++; end
      if (pend1) begin exp1 = shadow[bus.p1_addr[9:2]]; ld1++; end
      if (g0 && bus.p0_we) shadow[bus.p0_addr[9:2]] = bus.p0_wdata;
      if (g1 && bus.p1_we) shadow[bus.p1_addr[9:2]] = bus.p1_wdata;
      if (g0) last1 = 0;
      if (g1) last1 = 1;
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rnd_tail_rvalid0", bus.p0_rvalid, pend0);
    chk("rnd_tail_rvalid1", bus.p1_rvalid, pend1);
    if (bus.p0_rvalid) rv0++;
    if (bus.p1_rvalid) rv1++;
    if (pend0) chk("rnd_tail_rdata0", bus.p0_rdata, exp0);
    if (pend1) chk("rnd_tail_rdata1", bus.p1_rdata, exp1);
    chk("rnd_count0", rv0, ld0);
    chk("rnd_count1", rv1, ld1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameters: none; widths SHALL come from constants.vh (`ADDR_LEN`, `DATA_LEN`, both 32).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_x  in  1  reset, asynchronous, active-low.
REQ-004 p0_req  in  1  port 0 (LSU) request valid.
REQ-005 p0_we  in  1  port 0 write enable (1 = store, 0 = load).
REQ-006 p0_addr  in  `ADDR_LEN`  port 0 address.
REQ-007 p0_wdata  in  `DATA_LEN`  port 0 store data.
REQ-008 p0_gnt  out  1  port 0 request accepted this cycle.
REQ-009 p0_rvalid  out  1  port 0 load data valid.
REQ-010 p0_rdata  out  `DATA_LEN`  port 0 load data.
REQ-011 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same directions, widths and meanings as port 0, for port 1 (debug/DMA).
REQ-012 mem_addr  out  `ADDR_LEN`  address to dmem.
REQ-013 mem_wdata  out  `DATA_LEN`  write data to dmem.
REQ-014 mem_we  out  1  write enable to dmem.
REQ-015 mem_rdata  in  `DATA_LEN`  dmem read data; valid one cycle after the address is sampled.

Function
REQ-016 pN_gnt SHALL be combinational from the requests and arbitration state; a request is accepted on the rising edge at which pN_req=1 and pN_gnt=1.
REQ-017 A requester SHALL hold req, we, addr and wdata stable until granted; the arbiter does not latch unaccepted requests.
REQ-018 At most one of p0_gnt/p1_gnt SHALL be 1 in any cycle; pN_gnt SHALL never be 1 while pN_req=0.
REQ-019 With exactly one requester active, that requester SHALL be granted in the same cycle (zero-cycle arbitration, one access per cycle).
REQ-020 mem_addr, mem_wdata and mem_we SHALL mux from the granted port; mem_we SHALL equal the granted port's we and be 0 when nothing is granted.
REQ-021 When idle, mem_addr and mem_wdata SHALL follow port 0; with mem_we=0 they are don't-care.
REQ-022 A granted load (we=0) SHALL set a registered return tag; in the next cycle pN_rvalid=1 for exactly that port for exactly one cycle.
REQ-023 pN_rdata SHALL be mem_rdata, passed through combinationally; it is meaningful only while pN_rvalid=1.
REQ-024 Load latency SHALL be 1 cycle from grant edge to rvalid; back-to-back loads from either port SHALL sustain 1 per cycle.
REQ-025 A granted store SHALL produce no rvalid; store then load to the same address in consecutive cycles SHALL return the new data.
REQ-026 Responses SHALL have no backpressure; requesters always accept rvalid.

Reset
REQ-027 While reset_x=0: p0_gnt=p1_gnt=0, mem_we=0, p0_rvalid=p1_rvalid=0, return tag cleared, priority pointer = "port 1 last granted".
REQ-028 Reset asserted while a load is in flight SHALL drop its rvalid; after release the first grant follows the REQ-027 state.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN defined: round robin; under contention the port not granted last wins; the pointer updates only on an accepted grant.
REQ-030 DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins contention; the pointer register SHALL be absent.

Verification
REQ-031 Reset release, p0 load addr 0x10 with mem holding 0xDEADBEEF -> p0_gnt same cycle, p0_rvalid=1 with 0xDEADBEEF next cycle, p1_rvalid=0.
REQ-032 p1 store 0x20<-0x12345678, then p1 load 0x20 the next cycle -> mem_we=1 only in cycle 1, p1_rdata=0x12345678 in cycle 3.
REQ-033 RR_EN: both ports request loads for 4 cycles -> grants p0,p1,p0,p1, one rvalid per cycle to the matching port.
REQ-034 RR_EN undefined: both ports request for 4 cycles -> p0 granted all 4 cycles, p1_gnt=0 throughout.
REQ-035 p0 load granted, reset_x driven low before the next edge -> p0_rvalid stays 0, mem_we=0 during reset.
REQ-036 Random mixed traffic, 10k cycles -> never both gnt=1, rvalid count equals granted-load count per port, scoreboard data matches.
